// File: rtl/ava_bram_stream_reader_if.sv
// Valid/ready word stream produced by ava_bram_stream_reader.
// The master drives data/valid/last, the slave answers with ready.
interface ava_bram_stream_reader_if #(
  parameter int WORD_WIDTH = 32
) ();
  logic [WORD_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ava_bram_stream_reader.sv
// Sequential BRAM read engine: issues back-to-back reads from base_addr and
// streams the returned words through a 2-entry FIFO that hides read latency.
module ava_bram_stream_reader #(
  parameter  int WORD_COUNT = 1024,
  parameter  int WORD_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(WORD_COUNT),
  localparam int LEN_WIDTH  = $clog2(WORD_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_en,
  input  logic [WORD_WIDTH-1:0] mem_do,
  ava_bram_stream_reader_if.master m
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_reg, state_next;
  logic [LEN_WIDTH-1:0]  rem_issue_reg;
  logic [LEN_WIDTH-1:0]  rem_out_reg;
  logic [ADDR_WIDTH-1:0] mem_a_reg;
  logic                  inflight_reg;
  logic [1:0]            cnt_reg;
  logic [WORD_WIDTH-1:0] buf_reg [2];
  logic                  done_reg;

  logic       accept;
  logic       push;
  logic       pop;
  logic       last_pop;
  logic [2:0] occ_after;

  assign accept    = start && (state_reg == IDLE);
  assign push      = inflight_reg;
  assign pop       = (cnt_reg != 2'd0) && m.m_ready;
  assign last_pop  = pop && (rem_out_reg == LEN_WIDTH'(1));
  // Occupancy once this cycle's returning word lands and any handshake leaves.
  assign occ_after = 3'(cnt_reg) + 3'(inflight_reg) - 3'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && (length != '0)) state_next = RUN;
      RUN:     if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A read is only issued if its word is guaranteed a free slot on return;
  // gating on this cycle's handshake keeps full rate with only two entries.
  always_comb begin
    busy   = (state_reg == RUN);
    mem_en = (state_reg == RUN) && (rem_issue_reg != '0) && (occ_after < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_issue_reg <= '0;
      rem_out_reg   <= '0;
      mem_a_reg     <= '0;
      inflight_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg     <= (accept && (length == '0)) || last_pop;
      inflight_reg <= mem_en;
      if (accept) begin
        mem_a_reg     <= base_addr;
        rem_issue_reg <= length;
        rem_out_reg   <= length;
      end else begin
        if (mem_en) begin
          mem_a_reg     <= (mem_a_reg == ADDR_WIDTH'(WORD_COUNT - 1)) ? '0 : mem_a_reg + 1'b1;
          rem_issue_reg <= rem_issue_reg - 1'b1;
        end
        if (pop) begin
          rem_out_reg <= rem_out_reg - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= 2'd0;
      buf_reg[0] <= '0;
      buf_reg[1] <= '0;
    end else begin
      cnt_reg <= cnt_reg + 2'(push) - 2'(pop);
      case ({push, pop})
        2'b10: buf_reg[cnt_reg[0]] <= mem_do;
        2'b01: buf_reg[0] <= buf_reg[1];
        2'b11: begin
          if (cnt_reg == 2'd1) begin
            buf_reg[0] <= mem_do;
          end else begin
            buf_reg[0] <= buf_reg[1];
            buf_reg[1] <= mem_do;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_a     = mem_a_reg;
  assign done      = done_reg;
  assign m.m_data  = buf_reg[0];
  assign m.m_valid = (cnt_reg != 2'd0);
  assign m.m_last  = (cnt_reg != 2'd0) && (rem_out_reg == LEN_WIDTH'(1));

endmodule

// File: tb/tb_ava_bram_stream_reader.sv
// Bench for ava_bram_stream_reader: table of transfers checked against a
// count/queue based model of the stream, plus reset and busy-start sequences.
module tb_ava_bram_stream_reader;
  localparam int WC = 16;
  localparam int WW = 32;
  localparam int AW = $clog2(WC);
  localparam int LW = $clog2(WC + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_a;
  logic          mem_en;
  logic [WW-1:0] mem_do = '0;

  ava_bram_stream_reader_if #(.WORD_WIDTH(WW)) s_if ();

  ava_bram_stream_reader #(.WORD_COUNT(WC), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .busy(busy), .done(done), .mem_a(mem_a),
    .mem_en(mem_en), .mem_do(mem_do), .m(s_if.master)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [WC];
  initial for (int i = 0; i < WC; i++) mem[i] = 32'hA0 + i;
  always @(posedge clk) if (mem_en) mem_do <= mem[mem_a];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          base;
    int          len;
    int          mode;       // 0: ready high, 1: ready 50%, 2: 50% with a 10-cycle stall
    bit          poke;       // pulse a conflicting start mid-transfer
    int          exp_cycles; // edges from start to done, -1 when ready is random
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs [10];

  // Entered and left at posedge+1.
  task automatic run_xfer(input vec_t v);
    logic [31:0] q[$];
    int issued, handed, cyc, first_valid, max_out, buffered;
    bit seen_done, en_last, exp_valid, exp_pop, exp_en;
    logic [31:0] first_data, last_data;
    issued = 0; handed = 0; cyc = 0; first_valid = -1; max_out = 0;
    seen_done = 0; en_last = 0; first_data = '0; last_data = '0;
    for (int i = 0; i < v.len; i++) q.push_back(mem[(v.base + i) % WC]);

    start = 1'b1;
    base_addr = AW'(v.base);
    length = LW'(v.len);
    s_if.m_ready = (v.mode == 0) ? 1'b1 : 1'($urandom % 2);
    @(posedge clk);
    #1 start = 1'b0;

    while (!seen_done && cyc < 300) begin
      @(negedge clk);
      buffered  = issued - handed - int'(en_last);
      exp_valid = buffered > 0;
      exp_pop   = exp_valid && s_if.m_ready;
      exp_en    = (issued < v.len) && ((issued - handed - int'(exp_pop)) < 2);
      if (issued - handed > max_out) max_out = issued - handed;
      check("busy", busy, (v.len > 0) && (handed < v.len));
      check("done", done, handed == v.len);
      check("m_valid", s_if.m_valid, exp_valid);
      check("mem_en", mem_en, exp_en);
      if (mem_en) begin
        check("mem_a", mem_a, (v.base + issued) % WC);
        issued++;
      end
      if (s_if.m_valid && handed < v.len) begin
        if (first_valid < 0) first_valid = cyc;
        check("m_data", s_if.m_data, q[handed]);
        check("m_last", s_if.m_last, handed == v.len - 1);
        if (s_if.m_ready) begin
          if (handed == 0) first_data = s_if.m_data;
          last_data = s_if.m_data;
          handed++;
        end
      end
      if (done) seen_done = 1;
      en_last = mem_en;
      @(posedge clk);
      #1;
      cyc++;
      if (v.mode == 2 && cyc >= 3 && cyc < 13) s_if.m_ready = 1'b0;
      else if (v.mode != 0) s_if.m_ready = 1'($urandom % 2);
      if (v.poke && cyc == 2) begin
        start = 1'b1;
        base_addr = AW'(v.base ^ 8);
        length = LW'(2);
      end else begin
        start = 1'b0;
      end
    end

    if (!seen_done) begin
      fails++;
      $display("FAIL timeout: no done after %0d cycles, required within 300", cyc);
    end
    check("words", handed, v.len);
    check("max_outstanding_le2", max_out <= 2, 1);
    if (v.exp_cycles >= 0) check("done_cycle", cyc - 1, v.exp_cycles);
    if (v.len > 0) begin
      check("first_word", first_data, v.exp_first);
      check("last_word", last_data, v.exp_last);
      if (v.mode == 0) check("first_valid_edge", first_valid, 2);
    end
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("idle_busy", busy, 0);
    check("idle_mem_en", mem_en, 0);
    $display("[TB] xfer base=%0d len=%0d mode=%0d poke=%0d words=%0d cycles=%0d",
             v.base, v.len, v.mode, v.poke, handed, cyc - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_a"}, mem_a, 0);
    check({tag, "_m_valid"}, s_if.m_valid, 0);
    check({tag, "_m_last"}, s_if.m_last, 0);
    check({tag, "_m_data"}, s_if.m_data, 0);
  endtask

  initial begin
    int b, n, k, cyc;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    s_if.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    $display("[TB] reset values checked");
    @(posedge clk);
    #1 rst_n = 1'b1;

    vecs[0] = '{3, 4, 0, 0, 6, 32'hA3, 32'hA6};
    vecs[1] = '{14, 4, 0, 0, 6, 32'hAE, 32'hA1};
    vecs[2] = '{0, 0, 0, 0, 0, 32'h0, 32'h0};
    vecs[3] = '{0, 16, 0, 0, 18, 32'hA0, 32'hAF};
    vecs[4] = '{5, 8, 1, 0, -1, 32'hA5, 32'hAC};
    vecs[5] = '{2, 8, 2, 0, -1, 32'hA2, 32'hA9};
    vecs[6] = '{3, 4, 0, 1, 6, 32'hA3, 32'hA6};
    vecs[7] = '{9, 16, 2, 0, -1, 32'hA9, 32'hA8};
    for (int i = 8; i < 10; i++) begin
      b = int'($urandom % WC);
      n = 1 + int'($urandom % WC);
      vecs[i] = '{b, n, 1, 0, -1, 32'hA0 + b, 32'hA0 + ((b + n - 1) % WC)};
    end
    for (int i = 0; i < 10; i++) run_xfer(vecs[i]);

    // Reset in the middle of an 8-word transfer, after three handshakes.
    start = 1'b1;
    base_addr = '0;
    length = LW'(8);
    s_if.m_ready = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 50) begin
      @(negedge clk);
      if (s_if.m_valid && s_if.m_ready) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (k < 3) begin
      fails++;
      $display("FAIL reset_setup: %0d handshakes seen, required 3", k);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    $display("[TB] mid-transfer reset after %0d words checked", k);
    @(posedge clk);
    #1;
    run_xfer('{0, 2, 0, 0, 4, 32'hA0, 32'hA1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
